reg_file: RTL and testbench

- Architectural general-purpose register file for the single-cycle datapath.
- Sits directly upstream of the ALU: RD1 drives the ALU's SrcA, and RD2 drives the SrcB mux. The write port takes the ALU result or load data from the writeback mux.
- Two asynchronous read ports, one synchronous write port, and a debug read port for the testbench.
- Register 0 is hardwired to zero.

---
 rtl/reg_file.sv | 89 ++++++++
 tb/tb_reg_file.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: architectural register file for the single-cycle datapath.
//   clk       rising-edge clock
//   reset     synchronous active-high; clears every entry and wr_count
//   A1, A2    asynchronous read addresses -> RD1 (ALU SrcA), RD2 (SrcB mux / store data)
//   A3, WD3,  synchronous write port; a write to address 0 is discarded
//   WE3
//   dbg_addr  debug read address -> dbg_data (stored contents only, never forwarded)
//   wr_count  committed writes since reset, saturating at 16'hFFFF
// Register 0 always reads zero. With BYPASS=1, a same-cycle write is forwarded
// to RD1/RD2 (write-first); reset suppresses that forwarding.
module reg_file #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned BYPASS     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DEPTH_LOG2-1:0] A1,
    input  logic [DEPTH_LOG2-1:0] A2,
    input  logic [DEPTH_LOG2-1:0] A3,
    input  logic [WIDTH-1:0]      WD3,
    input  logic                  WE3,
    output logic [WIDTH-1:0]      RD1,
    output logic [WIDTH-1:0]      RD2,
    input  logic [DEPTH_LOG2-1:0] dbg_addr,
    output logic [WIDTH-1:0]      dbg_data,
    output logic [15:0]           wr_count
);

    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W     = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] mem [DEPTH];

    // A write only lands when out of reset, enabled, and not aimed at r0.
    logic commit_c;
    assign commit_c = !reset && WE3 && (A3 != '0);

    // Forwarding is only possible on a write that will actually commit.
    logic fwd_en_c;
    assign fwd_en_c = (BYPASS != 0) && commit_c;

    // Storage and write counter; reset wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_count <= '0;
        end else if (commit_c) begin
            mem[A3] <= WD3;
            if (wr_count != CNT_MAX) begin
                wr_count <= wr_count + CNT_W'(1);
            end
        end
    end

    // Read port 1: r0 is forced to zero ahead of any forwarding.
    always_comb begin
        RD1 = mem[A1];
        if (fwd_en_c && (A1 == A3)) begin
            RD1 = WD3;
        end
        if (A1 == '0) begin
            RD1 = '0;
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        RD2 = mem[A2];
        if (fwd_en_c && (A2 == A3)) begin
            RD2 = WD3;
        end
        if (A2 == '0) begin
            RD2 = '0;
        end
    end

    // Debug port shows stored contents only.
    always_comb begin
        dbg_data = mem[dbg_addr];
        if (dbg_addr == '0) begin
            dbg_data = '0;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed bench for reg_file. Two instances share all inputs,
// one built without forwarding (nb) and one with forwarding (b), so both
// bypass modes are exercised from the same stimulus.
module tb_reg_file;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned DEPTH_LOG2 = 5;

    logic                  clk;
    logic                  reset;
    logic [DEPTH_LOG2-1:0] A1, A2, A3, dbg_addr;
    logic [WIDTH-1:0]      WD3;
    logic                  WE3;

    logic [WIDTH-1:0] rd1_nb, rd2_nb, dbg_nb;
    logic [WIDTH-1:0] rd1_b,  rd2_b,  dbg_b;
    logic [15:0]      cnt_nb, cnt_b;

    int tests_run = 0;
    int tests_failed = 0;

    reg_file #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .BYPASS(0)) u_nb (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .WE3(WE3),
        .RD1(rd1_nb), .RD2(rd2_nb), .dbg_addr(dbg_addr), .dbg_data(dbg_nb),
        .wr_count(cnt_nb)
    );

    reg_file #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .BYPASS(1)) u_b (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .WE3(WE3),
        .RD1(rd1_b), .RD2(rd2_b), .dbg_addr(dbg_addr), .dbg_data(dbg_b),
        .wr_count(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, then let outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0; dbg_addr = '0;
        #2;

        // Reset with a competing write to r5.
        WE3 = 1'b1; A3 = 5'd5; WD3 = 32'hDEAD_BEEF;
        tick();
        reset = 1'b0; WE3 = 1'b0;
        #1;
        check("reset_cnt_nb", 32'(cnt_nb), 32'h0);
        check("reset_cnt_b",  32'(cnt_b),  32'h0);
        for (int a = 0; a < 32; a++) begin
            A1 = 5'(a); A2 = 5'(31 - a); dbg_addr = 5'(a);
            #1;
            check($sformatf("sweep_rd1_nb[%0d]", a), rd1_nb, 32'h0);
            check($sformatf("sweep_rd2_nb[%0d]", a), rd2_nb, 32'h0);
            check($sformatf("sweep_dbg_nb[%0d]", a), dbg_nb, 32'h0);
            check($sformatf("sweep_rd1_b[%0d]",  a), rd1_b,  32'h0);
        end

        // Basic writes to r8 and r31.
        WE3 = 1'b1; A3 = 5'd8; WD3 = 32'h0000_1234;
        tick();
        A3 = 5'd31; WD3 = 32'hFFFF_FFFF;
        tick();
        WE3 = 1'b0; A1 = 5'd8; A2 = 5'd31;
        #1;
        check("basic_rd1_nb", rd1_nb, 32'h0000_1234);
        check("basic_rd2_nb", rd2_nb, 32'hFFFF_FFFF);
        check("basic_rd1_b",  rd1_b,  32'h0000_1234);
        check("basic_cnt_nb", 32'(cnt_nb), 32'd2);
        A2 = 5'd8;
        #1;
        check("same_addr_rd2_nb", rd2_nb, 32'h0000_1234);

        // Write to r0 is discarded, even through the bypass path.
        WE3 = 1'b1; A3 = 5'd0; WD3 = 32'hA5A5_A5A5; A1 = 5'd0;
        #1;
        check("r0_bypass_rd1_b", rd1_b, 32'h0);
        tick();
        WE3 = 1'b0;
        #1;
        check("r0_rd1_nb", rd1_nb, 32'h0);
        check("r0_cnt_nb", 32'(cnt_nb), 32'd2);
        check("r0_cnt_b",  32'(cnt_b),  32'd2);

        // Forwarding: r3 = 0x11, then overwrite with 0x22 while reading r3.
        WE3 = 1'b1; A3 = 5'd3; WD3 = 32'h11;
        tick();
        WD3 = 32'h22; A1 = 5'd3; A2 = 5'd3; dbg_addr = 5'd3;
        #1;
        check("byp0_rd1_same", rd1_nb, 32'h11);
        check("byp0_rd2_same", rd2_nb, 32'h11);
        check("byp1_rd1_same", rd1_b,  32'h22);
        check("byp1_rd2_same", rd2_b,  32'h22);
        check("byp1_dbg_same", dbg_b,  32'h11);
        tick();
        WE3 = 1'b0;
        #1;
        check("byp0_rd1_next", rd1_nb, 32'h22);
        check("byp0_rd2_next", rd2_nb, 32'h22);
        check("byp1_dbg_next", dbg_b,  32'h22);
        check("byp_cnt_nb", 32'(cnt_nb), 32'd4);

        // Reset mid-operation with a competing write to r7.
        WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h77;
        tick();
        reset = 1'b1; WD3 = 32'h99; A1 = 5'd7; A2 = 5'd8; dbg_addr = 5'd7;
        #1;
        check("rst_pre_rd1_b",  rd1_b,  32'h77);
        check("rst_pre_rd1_nb", rd1_nb, 32'h77);
        check("rst_pre_cnt_b",  32'(cnt_b), 32'd5);
        tick();
        reset = 1'b0; WE3 = 1'b0;
        #1;
        check("rst_r7_nb",  rd1_nb, 32'h0);
        check("rst_r7_b",   rd1_b,  32'h0);
        check("rst_r8_nb",  rd2_nb, 32'h0);
        check("rst_dbg_nb", dbg_nb, 32'h0);
        check("rst_cnt_nb", 32'(cnt_nb), 32'h0);
        check("rst_cnt_b",  32'(cnt_b),  32'h0);

        // Saturation: repeated writes to r1.
        WE3 = 1'b1; A3 = 5'd1;
        for (int i = 0; i < 65534; i++) begin
            WD3 = 32'(i);
            tick();
        end
        check("sat_cnt_fffe", 32'(cnt_nb), 32'h0000_FFFE);
        tick();
        check("sat_cnt_ffff", 32'(cnt_nb), 32'h0000_FFFF);
        tick();
        WD3 = 32'hCAFE_0001;
        tick();
        WE3 = 1'b0; A1 = 5'd1;
        #1;
        check("sat_hold_nb", 32'(cnt_nb), 32'h0000_FFFF);
        check("sat_hold_b",  32'(cnt_b),  32'h0000_FFFF);
        check("sat_r1_data", rd1_nb, 32'hCAFE_0001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
